// File: rtl/freq_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_seq_pkg
// Description : Shared types for the freq profile sequencer: FSM state
//               encoding, profile-entry field widths, the packed entry
//               layout and a saturating dwell decrement helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package freq_seq_pkg;

    localparam int FREQ_W  = 32;
    localparam int PHA_W   = 32;
    localparam int PULSE_W = 16;
    localparam int DWELL_W = 32;
    // freq + pha + pulses + limited flag + dwell = 113 bits
    localparam int ENTRY_W = FREQ_W + PHA_W + PULSE_W + 1 + DWELL_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_ARM    = 3'd3,
        S_DWELL  = 3'd4,
        S_NEXT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0]  freq;
        logic [PHA_W-1:0]   pha;
        logic [PULSE_W-1:0] pulses;
        logic               limited;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    // Dwell counter never wraps below zero.
    function automatic logic [DWELL_W-1:0] dwell_dec(input logic [DWELL_W-1:0] v);
        return (v == '0) ? '0 : v - DWELL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_profile_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : freq_profile_seq_if
// Description : Bundles the host-side table/control signals and the
//               freq-channel-side config/status signals of the sequencer.
//               master : host/driver side (drives I_*, observes O_*)
//               slave  : sequencer side (observes I_*, drives O_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface freq_profile_seq_if #(
    parameter int AW = 3
);
    import freq_seq_pkg::*;

    // host table port
    logic                I_cfg_we;
    logic [AW-1:0]       I_cfg_addr;
    logic [FREQ_W-1:0]   I_cfg_freq;
    logic [PHA_W-1:0]    I_cfg_pha;
    logic [PULSE_W-1:0]  I_cfg_pulses;
    logic                I_cfg_limited;
    logic [DWELL_W-1:0]  I_cfg_dwell;
    // sequence control
    logic [AW-1:0]       I_last_idx;
    logic                I_loop;
    logic                I_clr_pulse;
    logic                I_start;
    logic                I_abort;
    // from freq channel
    logic                I_finished;
    // to freq channel
    logic [FREQ_W-1:0]   O_freq;
    logic [PHA_W-1:0]    O_pha;
    logic [PULSE_W-1:0]  O_pluse_number;
    logic                O_limited;
    logic [1:0]          O_load;
    logic [31:0]         O_init_pulse;
    logic                O_stat;
    // sequence status
    logic                O_busy;
    logic [AW-1:0]       O_idx;
    logic                O_done;
    logic                O_timeout;

    modport master (
        output I_cfg_we, I_cfg_addr, I_cfg_freq, I_cfg_pha, I_cfg_pulses,
               I_cfg_limited, I_cfg_dwell, I_last_idx, I_loop, I_clr_pulse,
               I_start, I_abort, I_finished,
        input  O_freq, O_pha, O_pluse_number, O_limited, O_load, O_init_pulse,
               O_stat, O_busy, O_idx, O_done, O_timeout
    );

    modport slave (
        input  I_cfg_we, I_cfg_addr, I_cfg_freq, I_cfg_pha, I_cfg_pulses,
               I_cfg_limited, I_cfg_dwell, I_last_idx, I_loop, I_clr_pulse,
               I_start, I_abort, I_finished,
        output O_freq, O_pha, O_pluse_number, O_limited, O_load, O_init_pulse,
               O_stat, O_busy, O_idx, O_done, O_timeout
    );

endinterface
`default_nettype wire

// File: rtl/freq_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : freq_seq_table
// Description : DEPTH x ENTRY_W profile register file. Synchronous write,
//               asynchronous read, synchronous zeroing on reset.
// Ports       : clk, reset_n (sync, active low), we/waddr/wdata (write),
//               raddr/rdata (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module freq_seq_table
    import freq_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/freq_profile_seq.sv
`default_nettype none
// ============================================================================
// Module      : freq_profile_seq
// Description : Steps one freq tachometer channel through a table of speed
//               profiles. Each visit latches an entry onto the config
//               outputs, pulses the load strobe(s), waits for the channel to
//               settle, then dwells until timeout or limited-mode finish.
// Ports       : I_clk, I_reset_n (sync, active low)
//               bus (slave) : table writes, start/abort/loop control,
//                             freq config outputs, busy/idx/done/timeout
// Revision    : 1.0 - initial release
// ============================================================================
module freq_profile_seq
    import freq_seq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int LOAD_HOLD = 4
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    freq_profile_seq_if.slave bus
);

    localparam int c_HOLD_W = $clog2(LOAD_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(LOAD_HOLD - 1);

    state_t               r_state, w_state_nxt;
    logic [AW-1:0]        r_idx, w_idx_nxt;
    logic [c_HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic                 r_init, w_init_nxt;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   r_dwell;
    logic [FREQ_W-1:0]    r_freq;
    logic [PHA_W-1:0]     r_pha;
    logic [PULSE_W-1:0]   r_pulses;
    logic                 r_limited;
    logic [1:0]           r_load;
    logic                 r_stat, r_busy, r_done, r_timeout;

    logic                 w_done_nxt, w_to_set, w_start_acc;
    logic                 w_enter_load, w_enter_arm, w_expire;
    entry_t               w_rd_entry, w_wr_entry;

    assign w_wr_entry = '{freq:    bus.I_cfg_freq,
                          pha:     bus.I_cfg_pha,
                          pulses:  bus.I_cfg_pulses,
                          limited: bus.I_cfg_limited,
                          dwell:   bus.I_cfg_dwell};

    // Read port follows the index being entered so the entry can be
    // latched on the same edge that enters LOAD.
    freq_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .clk     (I_clk),
        .reset_n (I_reset_n),
        .we      (bus.I_cfg_we),
        .waddr   (bus.I_cfg_addr),
        .wdata   (w_wr_entry),
        .raddr   (w_idx_nxt),
        .rdata   (w_rd_entry)
    );

    // Counter is preloaded with dwell-1 as ARM is entered, so the ARM cycle
    // itself counts; reaching 1 in DWELL means N clocks including NEXT.
    assign w_expire = (r_dwell != '0) && (r_cnt <= DWELL_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_hold_nxt   = r_hold;
        w_init_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_to_set     = 1'b0;
        w_start_acc  = 1'b0;
        w_enter_load = 1'b0;
        w_enter_arm  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.I_start) begin
                    w_state_nxt  = S_LOAD;
                    w_idx_nxt    = '0;
                    w_hold_nxt   = c_HOLD_INIT;
                    w_init_nxt   = bus.I_clr_pulse;
                    w_start_acc  = 1'b1;
                    w_enter_load = 1'b1;
                end
            end
            S_LOAD: begin
                w_init_nxt = r_init;
                if (r_hold == '0) begin
                    w_state_nxt = S_SETTLE;
                    w_hold_nxt  = c_HOLD_INIT;
                end else begin
                    w_hold_nxt = r_hold - c_HOLD_W'(1);
                end
            end
            S_SETTLE: begin
                if (r_hold == '0) begin
                    w_state_nxt = S_ARM;
                    w_enter_arm = 1'b1;
                end else begin
                    w_hold_nxt = r_hold - c_HOLD_W'(1);
                end
            end
            S_ARM: begin
                // A finished flag still high from the previous entry must
                // drop before a limited entry starts watching it.
                if (!r_limited || !bus.I_finished) begin
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (r_limited) begin
                    if (bus.I_finished) begin
                        w_state_nxt = S_NEXT;
                    end else if (w_expire) begin
                        w_state_nxt = S_NEXT;
                        w_to_set    = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if ((r_idx == bus.I_last_idx) && !bus.I_loop) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt  = S_LOAD;
                    w_idx_nxt    = (r_idx == bus.I_last_idx) ? '0 : r_idx + AW'(1);
                    w_hold_nxt   = c_HOLD_INIT;
                    w_enter_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (bus.I_abort) begin
            w_state_nxt  = S_IDLE;
            w_idx_nxt    = r_idx;
            w_hold_nxt   = r_hold;
            w_init_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
            w_to_set     = 1'b0;
            w_start_acc  = 1'b0;
            w_enter_load = 1'b0;
            w_enter_arm  = 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            r_idx     <= '0;
            r_hold    <= '0;
            r_init    <= 1'b0;
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_freq    <= '0;
            r_pha     <= '0;
            r_pulses  <= '0;
            r_limited <= 1'b0;
            r_load    <= 2'b00;
            r_stat    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_hold <= w_hold_nxt;
            r_init <= w_init_nxt;
            r_load <= {(w_state_nxt == S_LOAD) && w_init_nxt, w_state_nxt == S_LOAD};
            r_stat <= (w_state_nxt != S_IDLE);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_done_nxt;

            if (w_enter_load) begin
                r_freq    <= w_rd_entry.freq;
                r_pha     <= w_rd_entry.pha;
                r_pulses  <= w_rd_entry.pulses;
                r_limited <= w_rd_entry.limited;
                r_dwell   <= w_rd_entry.dwell;
            end

            if (w_enter_arm) begin
                r_cnt <= dwell_dec(r_dwell);
            end else if ((r_state == S_ARM) || (r_state == S_DWELL)) begin
                r_cnt <= dwell_dec(r_cnt);
            end

            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.O_freq         = r_freq;
    assign bus.O_pha          = r_pha;
    assign bus.O_pluse_number = r_pulses;
    assign bus.O_limited      = r_limited;
    assign bus.O_load         = r_load;
    assign bus.O_init_pulse   = '0;
    assign bus.O_stat         = r_stat;
    assign bus.O_busy         = r_busy;
    assign bus.O_idx          = r_idx;
    assign bus.O_done         = r_done;
    assign bus.O_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_freq_profile_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_freq_profile_seq
// Description : Directed bench for freq_profile_seq. Expected load-strobe
//               and done events are queued as stimulus is issued and checked
//               by a negedge monitor; state checks are made inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_profile_seq;

    localparam int LOAD_HOLD = 4;

    typedef struct {
        int          cyc;
        logic [1:0]  load;
        logic [31:0] freq;
        logic [2:0]  idx;
    } ld_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   t0;

    ld_t  exp_ld[$];
    int   exp_done[$];

    freq_profile_seq_if #(.AW(3)) bus();

    freq_profile_seq #(.DEPTH(8), .AW(3), .LOAD_HOLD(LOAD_HOLD)) dut (
        .I_clk     (clk),
        .I_reset_n (reset_n),
        .bus       (bus.slave)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic prev_ld = 1'b0;
    int   ld_len = 0;
    always @(negedge clk) begin
        ld_t e;
        if (bus.O_load[0] === 1'b1 && !prev_ld) begin
            chk("load_expected", exp_ld.size() > 0, 1);
            if (exp_ld.size() > 0) begin
                e = exp_ld.pop_front();
                chk("load_cycle", cyc, e.cyc);
                chk("load_value", bus.O_load, e.load);
                chk("load_freq",  bus.O_freq, e.freq);
                chk("load_idx",   bus.O_idx,  e.idx);
            end
        end
        if (bus.O_load[0] !== 1'b1 && prev_ld) begin
            chk("load_len", ld_len, LOAD_HOLD);
        end
        ld_len  = (bus.O_load[0] === 1'b1) ? ld_len + 1 : 0;
        prev_ld = (bus.O_load[0] === 1'b1);
        if (bus.O_done === 1'b1) begin
            chk("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] f, input logic [31:0] p,
                      input logic [15:0] n, input logic lim, input logic [31:0] d);
        bus.I_cfg_we = 1'b1; bus.I_cfg_addr = a; bus.I_cfg_freq = f; bus.I_cfg_pha = p;
        bus.I_cfg_pulses = n; bus.I_cfg_limited = lim; bus.I_cfg_dwell = d;
        step(1);
        bus.I_cfg_we = 1'b0;
    endtask

    task automatic exp_load(input int c, input logic [1:0] l, input logic [31:0] f, input logic [2:0] i);
        ld_t e;
        e.cyc = c; e.load = l; e.freq = f; e.idx = i;
        exp_ld.push_back(e);
    endtask

    // Start pulse is driven in cycle t0; returns one cycle later.
    task automatic do_start();
        bus.I_start = 1'b1;
        t0 = cyc;
        step(1);
        bus.I_start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.I_abort = 1'b1;
        step(1);
        bus.I_abort = 1'b0;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_loads_left"}, exp_ld.size(), 0);
        chk({tag, "_dones_left"}, exp_done.size(), 0);
    endtask

    // Per-entry period for a non-limited entry: load + settle + dwell.
    function automatic int period(input int dwell);
        return 2 * LOAD_HOLD + dwell;
    endfunction

    initial begin
        bus.I_cfg_we = 0; bus.I_cfg_addr = 0; bus.I_cfg_freq = 0; bus.I_cfg_pha = 0;
        bus.I_cfg_pulses = 0; bus.I_cfg_limited = 0; bus.I_cfg_dwell = 0;
        bus.I_last_idx = 0; bus.I_loop = 0; bus.I_clr_pulse = 0;
        bus.I_start = 0; bus.I_abort = 0; bus.I_finished = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq", bus.O_freq, 0);
        chk("rst_load", bus.O_load, 0);
        chk("rst_stat", bus.O_stat, 0);
        chk("rst_busy", bus.O_busy, 0);
        chk("rst_done", bus.O_done, 0);
        chk("rst_init_pulse", bus.O_init_pulse, 0);
        reset_n = 1'b1;
        step(2);

        // ---- 1: two non-limited entries ----
        wr(0, 1000, 32'h0000_0001, 0, 0, 50);
        wr(1, 2000, 32'h8000_0010, 0, 0, 30);
        bus.I_last_idx = 1; bus.I_loop = 0;
        step(1);
        exp_load(cyc + 1, 2'b01, 1000, 0);
        exp_load(cyc + 1 + period(50), 2'b01, 2000, 1);
        exp_done.push_back(cyc + 1 + period(50) + period(30));
        do_start();
        chk("t1_stat_up", bus.O_stat, 1);
        chk("t1_busy_up", bus.O_busy, 1);
        to_cycle(t0 + 60);
        chk("t1_pha_dir", bus.O_pha, 32'h8000_0010);
        to_cycle(t0 + 96);
        chk("t1_busy_last", bus.O_busy, 1);
        to_cycle(t0 + 97);
        chk("t1_busy_fall", bus.O_busy, 0);
        chk("t1_stat_fall", bus.O_stat, 0);
        chk("t1_timeout", bus.O_timeout, 0);
        step(10);
        queues_empty("t1");

        // ---- 2: limited entry, stale finished ----
        wr(0, 3000, 0, 5, 1, 0);
        bus.I_last_idx = 0;
        bus.I_finished = 1'b1;
        step(1);
        exp_load(cyc + 1, 2'b01, 3000, 0);
        exp_done.push_back(cyc + 42);
        do_start();
        to_cycle(t0 + 13);
        bus.I_finished = 1'b0;
        to_cycle(t0 + 20);
        chk("t2_limited", bus.O_limited, 1);
        chk("t2_pulses", bus.O_pluse_number, 5);
        to_cycle(t0 + 40);
        chk("t2_busy_wait", bus.O_busy, 1);
        bus.I_finished = 1'b1;
        to_cycle(t0 + 42);
        chk("t2_busy_fall", bus.O_busy, 0);
        chk("t2_timeout", bus.O_timeout, 0);
        bus.I_finished = 1'b0;
        step(5);
        queues_empty("t2");

        // ---- 3: limited timeout ----
        wr(0, 4000, 0, 7, 1, 20);
        step(1);
        exp_load(cyc + 1, 2'b01, 4000, 0);
        exp_done.push_back(cyc + 1 + period(20));
        do_start();
        to_cycle(t0 + 27);
        chk("t3_timeout_early", bus.O_timeout, 0);
        to_cycle(t0 + 35);
        chk("t3_timeout_set", bus.O_timeout, 1);
        chk("t3_busy", bus.O_busy, 0);
        step(10);
        chk("t3_timeout_sticky", bus.O_timeout, 1);
        queues_empty("t3");

        // ---- 4: loop wrap, rewrite of active entry, abort ----
        for (int i = 0; i < 3; i++) wr(3'(i), 32'(100 * (i + 1)), 0, 0, 0, 10);
        bus.I_last_idx = 2; bus.I_loop = 1;
        step(1);
        exp_load(cyc + 1,                2'b01, 100, 0);
        exp_load(cyc + 1 + period(10),   2'b01, 200, 1);
        exp_load(cyc + 1 + 2*period(10), 2'b01, 300, 2);
        exp_load(cyc + 1 + 3*period(10), 2'b01, 111, 0);
        exp_load(cyc + 1 + 4*period(10), 2'b01, 200, 1);
        do_start();
        chk("t4_timeout_clr", bus.O_timeout, 0);
        to_cycle(t0 + 5);
        wr(0, 111, 0, 0, 0, 10);
        to_cycle(t0 + 10);
        chk("t4_active_kept", bus.O_freq, 100);
        to_cycle(t0 + 30);
        bus.I_start = 1'b1;
        step(1);
        bus.I_start = 1'b0;
        to_cycle(t0 + 80);
        chk("t4_idx_before_abort", bus.O_idx, 1);
        pulse_abort();
        chk("t4_abort_stat", bus.O_stat, 0);
        chk("t4_abort_busy", bus.O_busy, 0);
        chk("t4_abort_load", bus.O_load, 0);
        chk("t4_abort_freq_kept", bus.O_freq, 200);
        step(40);
        chk("t4_still_idle", bus.O_busy, 0);
        queues_empty("t4");

        // ---- 5: init pulse and reset mid-run ----
        wr(0, 500, 32'h1234, 3, 0, 10);
        wr(1, 600, 32'h5678, 4, 0, 10);
        bus.I_last_idx = 1; bus.I_loop = 0; bus.I_clr_pulse = 1;
        step(1);
        exp_load(cyc + 1,              2'b11, 500, 0);
        exp_load(cyc + 1 + period(10), 2'b01, 600, 1);
        do_start();
        bus.I_clr_pulse = 0;
        to_cycle(t0 + 30);
        chk("t5_busy_dwell", bus.O_busy, 1);
        reset_n = 1'b0;
        step(1);
        chk("t5_rst_freq", bus.O_freq, 0);
        chk("t5_rst_pha", bus.O_pha, 0);
        chk("t5_rst_pulses", bus.O_pluse_number, 0);
        chk("t5_rst_stat", bus.O_stat, 0);
        chk("t5_rst_busy", bus.O_busy, 0);
        chk("t5_rst_idx", bus.O_idx, 0);
        chk("t5_rst_load", bus.O_load, 0);
        step(1);
        reset_n = 1'b1;
        bus.I_last_idx = 0;
        step(2);
        queues_empty("t5");

        // Zeroed table: entry 0 now has dwell 0, so it holds until abort.
        exp_load(cyc + 1, 2'b01, 0, 0);
        do_start();
        to_cycle(t0 + 40);
        chk("t6_hold_forever", bus.O_busy, 1);
        chk("t6_pha_zero", bus.O_pha, 0);
        pulse_abort();
        chk("t6_abort_busy", bus.O_busy, 0);
        step(5);
        queues_empty("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
